timer_reader: RTL and testbench



---
 rtl/timer_pkg.sv | 19 +
 rtl/sync_fifo.sv | 91 +++++++++
 rtl/timer_reader.sv | 131 +++++++++++++
 tb/tb_timer_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : timer_pkg                                                    |
// | Description : Shared types and constants for the timer_reader block.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package timer_pkg;

    localparam int          DATA_W          = 16;
    localparam logic [31:0] TIMEOUT_DEFAULT = 32'd5_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo                                                    |
// | Description : Single-clock FIFO with registered read data and flags.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              pop_ok;
    logic              push_ok;

    always_comb begin
        pop_ok     = pop & ~empty_q;
        // A full FIFO still takes a push when a pop frees the slot this cycle.
        push_ok    = push & (~full_q | pop_ok);
        drop       = push & ~push_ok;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_ok;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign full     = full_q;
    assign empty    = empty_q;

endmodule
`default_nettype wire

// File: rtl/timer_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : timer_reader                                                 |
// | Description : Arms a word producer, buffers a fixed number of samples and  |
// |               hands them to a display-side reader; aborts on silence.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module timer_reader
    import timer_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter int          SAMPLES = 4,
    parameter logic [31:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              t_en,
    input  logic              t_valid,
    input  logic [DATA_W-1:0] t_out,
    input  logic              rd_en,
    output logic [DATA_W-1:0] d_out,
    output logic              d_valid,
    output logic              busy,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              timeout
);

    localparam logic [7:0]  SAMPLE_LAST  = 8'(SAMPLES);
    localparam logic [31:0] SILENCE_LAST = TIMEOUT - 32'd1;

    state_t      state_q, state_d;
    logic        start_q;
    logic        start_rise;
    logic [7:0]  sample_cnt_q, sample_cnt_d;
    logic [31:0] silence_q, silence_d;
    logic        timeout_q, timeout_d;
    logic        overflow_q, overflow_d;
    logic        t_en_q, t_en_d;
    logic        push;
    logic        fifo_drop;

    always_comb begin
        start_rise   = start & ~start_q;
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        silence_d    = silence_q;
        timeout_d    = timeout_q;
        overflow_d   = overflow_q | fifo_drop;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d      = ACQ;
                    sample_cnt_d = '0;
                    silence_d    = '0;
                    timeout_d    = 1'b0;
                    overflow_d   = 1'b0;
                end
            end
            ACQ: begin
                if (t_valid) begin
                    push         = 1'b1;
                    sample_cnt_d = sample_cnt_q + 8'd1;
                    silence_d    = '0;
                    if (sample_cnt_d == SAMPLE_LAST) begin
                        state_d = DONE;
                    end
                end else if (silence_q == SILENCE_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    silence_d = silence_q + 32'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Enable is registered from the next state so it never glitches on decode.
        t_en_d = (state_d == ACQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            sample_cnt_q <= '0;
            silence_q    <= '0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            t_en_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            sample_cnt_q <= sample_cnt_d;
            silence_q    <= silence_d;
            timeout_q    <= timeout_d;
            overflow_q   <= overflow_d;
            t_en_q       <= t_en_d;
        end
    end

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (t_out),
        .pop       (rd_en),
        .rd_data   (d_out),
        .rd_valid  (d_valid),
        .full      (full),
        .empty     (empty),
        .drop      (fifo_drop)
    );

    assign t_en     = t_en_q;
    assign busy     = t_en_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_timer_reader                                              |
// | Description : Directed bench for timer_reader (DEPTH=8 and DEPTH=2 copies).|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_timer_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        t_valid;
    logic [15:0] t_out;
    logic        rd_en;

    logic        a_t_en, a_d_valid, a_busy, a_empty, a_full, a_overflow, a_timeout;
    logic [15:0] a_d_out;
    logic        b_t_en, b_d_valid, b_busy, b_empty, b_full, b_overflow, b_timeout;
    logic [15:0] b_d_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_reader #(.DEPTH(8), .SAMPLES(4), .TIMEOUT(32'd20)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .t_en(a_t_en), .t_valid(t_valid),
        .t_out(t_out), .rd_en(rd_en), .d_out(a_d_out), .d_valid(a_d_valid),
        .busy(a_busy), .empty(a_empty), .full(a_full), .overflow(a_overflow),
        .timeout(a_timeout)
    );

    timer_reader #(.DEPTH(2), .SAMPLES(4), .TIMEOUT(32'd20)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .t_en(b_t_en), .t_valid(t_valid),
        .t_out(t_out), .rd_en(rd_en), .d_out(b_d_out), .d_valid(b_d_valid),
        .busy(b_busy), .empty(b_empty), .full(b_full), .overflow(b_overflow),
        .timeout(b_timeout)
    );

    typedef struct {
        int start, tv, tout, rd;
        int e_ten, e_busy, e_empty, e_full, e_dv, e_dout, e_to, e_ov;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are read at the same point.
    task automatic step(input int s, input int tv, input int d, input int rd);
        start   = 1'(s);
        t_valid = 1'(tv);
        t_out   = 16'(d);
        rd_en   = 1'(rd);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int en_cycles;
        int cnt;
        int rises;
        logic prev;

        //        start tv tout     rd | ten busy empty full dv dout     to ov
        tbl[0]  = '{1, 0, 'h0000, 0,   1, 1, 1, 0, 0, 'h0000, 0, 0};
        tbl[1]  = '{1, 1, 'h1111, 0,   1, 1, 0, 0, 0, 'h0000, 0, 0};
        tbl[2]  = '{0, 1, 'h2222, 0,   1, 1, 0, 0, 0, 'h0000, 0, 0};
        tbl[3]  = '{0, 0, 'h0000, 1,   1, 1, 0, 0, 1, 'h1111, 0, 0};
        tbl[4]  = '{0, 1, 'h3333, 1,   1, 1, 0, 0, 1, 'h2222, 0, 0};
        tbl[5]  = '{0, 1, 'h4444, 0,   0, 0, 0, 0, 0, 'h2222, 0, 0};
        tbl[6]  = '{0, 1, 'h5555, 0,   0, 0, 0, 0, 0, 'h2222, 0, 0};
        tbl[7]  = '{0, 1, 'h6666, 1,   0, 0, 0, 0, 1, 'h3333, 0, 0};
        tbl[8]  = '{0, 0, 'h0000, 1,   0, 0, 1, 0, 1, 'h4444, 0, 0};
        tbl[9]  = '{0, 0, 'h0000, 1,   0, 0, 1, 0, 0, 'h4444, 0, 0};
        tbl[10] = '{1, 0, 'h0000, 0,   1, 1, 1, 0, 0, 'h4444, 0, 0};

        rst = 1'b1; start = 1'b0; t_valid = 1'b0; t_out = 16'h0; rd_en = 1'b0;

        do_reset();
        chk("rst a_t_en",     32'(a_t_en),     0);
        chk("rst a_busy",     32'(a_busy),     0);
        chk("rst a_empty",    32'(a_empty),    1);
        chk("rst a_full",     32'(a_full),     0);
        chk("rst a_d_valid",  32'(a_d_valid),  0);
        chk("rst a_d_out",    32'(a_d_out),    0);
        chk("rst a_overflow", 32'(a_overflow), 0);
        chk("rst a_timeout",  32'(a_timeout),  0);
        chk("rst b_empty",    32'(b_empty),    1);
        chk("rst b_full",     32'(b_full),     0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].start, tbl[i].tv, tbl[i].tout, tbl[i].rd);
            chk($sformatf("vec%0d t_en", i),     32'(a_t_en),     tbl[i].e_ten);
            chk($sformatf("vec%0d busy", i),     32'(a_busy),     tbl[i].e_busy);
            chk($sformatf("vec%0d empty", i),    32'(a_empty),    tbl[i].e_empty);
            chk($sformatf("vec%0d full", i),     32'(a_full),     tbl[i].e_full);
            chk($sformatf("vec%0d d_valid", i),  32'(a_d_valid),  tbl[i].e_dv);
            chk($sformatf("vec%0d d_out", i),    32'(a_d_out),    tbl[i].e_dout);
            chk($sformatf("vec%0d timeout", i),  32'(a_timeout),  tbl[i].e_to);
            chk($sformatf("vec%0d overflow", i), 32'(a_overflow), tbl[i].e_ov);
        end

        // Basic capture: words 1..4 every 10 cycles, 40 enabled cycles in total.
        do_reset();
        step(1, 0, 0, 0);
        en_cycles = int'(a_t_en);
        for (int w = 1; w <= 4; w++) begin
            for (int g = 0; g < 9; g++) begin
                step(0, 0, 0, 0);
                en_cycles += int'(a_t_en);
            end
            step(0, 1, w, 0);
            if (w < 4) en_cycles += int'(a_t_en);
        end
        chk("basic t_en cycles", 32'(en_cycles), 40);
        chk("basic t_en low after last", 32'(a_t_en), 0);
        chk("basic busy low after last", 32'(a_busy), 0);
        step(0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 1);
            chk($sformatf("basic pop%0d d_valid", k), 32'(a_d_valid), 1);
            chk($sformatf("basic pop%0d d_out", k),   32'(a_d_out),   32'(k));
            step(0, 0, 0, 0);
            chk($sformatf("basic pop%0d d_valid drop", k), 32'(a_d_valid), 0);
        end
        chk("basic empty after pops", 32'(a_empty), 1);

        // Timeout after 20 silent enabled cycles; next start clears it.
        do_reset();
        step(1, 0, 0, 0);
        cnt = 0;
        while (a_t_en && cnt < 100) begin
            cnt++;
            step(0, 0, 0, 0);
        end
        chk("timeout acq cycles", 32'(cnt), 20);
        chk("timeout flag",       32'(a_timeout), 1);
        chk("timeout t_en",       32'(a_t_en),    0);
        chk("timeout empty",      32'(a_empty),   1);
        step(1, 0, 0, 0);
        chk("timeout cleared",    32'(a_timeout), 0);
        chk("timeout restart t_en", 32'(a_t_en),  1);

        // Overflow on DEPTH=2.
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 'hAAAA, 0);
        step(0, 0, 0, 0);
        step(0, 1, 'hBBBB, 0);
        chk("ovf full after 2nd", 32'(b_full), 1);
        chk("ovf clear after 2nd", 32'(b_overflow), 0);
        step(0, 0, 0, 0);
        step(0, 1, 'hCCCC, 0);
        chk("ovf set after 3rd", 32'(b_overflow), 1);
        step(0, 0, 0, 0);
        step(0, 1, 'hDDDD, 0);
        chk("ovf done t_en", 32'(b_t_en), 0);
        step(0, 0, 0, 1);
        chk("ovf pop1 d_out", 32'(b_d_out), 'hAAAA);
        chk("ovf pop1 d_valid", 32'(b_d_valid), 1);
        step(0, 0, 0, 1);
        chk("ovf pop2 d_out", 32'(b_d_out), 'hBBBB);
        step(0, 0, 0, 1);
        chk("ovf pop3 d_valid", 32'(b_d_valid), 0);
        chk("ovf pop3 d_out", 32'(b_d_out), 'hBBBB);
        chk("ovf empty", 32'(b_empty), 1);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 5, 0);
        step(0, 1, 6, 0);
        chk("pp full", 32'(b_full), 1);
        step(0, 1, 7, 1);
        chk("pp d_out", 32'(b_d_out), 5);
        chk("pp d_valid", 32'(b_d_valid), 1);
        chk("pp still full", 32'(b_full), 1);
        chk("pp no overflow", 32'(b_overflow), 0);
        step(0, 0, 0, 1);
        chk("pp pop 6", 32'(b_d_out), 6);
        step(0, 0, 0, 1);
        chk("pp pop 7", 32'(b_d_out), 7);
        chk("pp empty", 32'(b_empty), 1);

        // Empty pop, then start held high for 100 cycles.
        do_reset();
        step(0, 0, 0, 1);
        chk("empty pop d_valid", 32'(a_d_valid), 0);
        chk("empty pop d_out", 32'(a_d_out), 0);
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1, 0, 0, 0);
            if (a_t_en && !prev) rises++;
            prev = a_t_en;
        end
        chk("hold single acquisition", 32'(rises), 1);
        chk("hold t_en idle", 32'(a_t_en), 0);

        // Reset in the middle of an acquisition.
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 1, 2, 0);
        chk("midrst pre empty", 32'(a_empty), 0);
        rst = 1'b1;
        step(0, 0, 0, 0);
        chk("midrst t_en", 32'(a_t_en), 0);
        chk("midrst empty", 32'(a_empty), 1);
        chk("midrst busy", 32'(a_busy), 0);
        rst = 1'b0;
        step(0, 1, 9, 0);
        step(0, 1, 10, 0);
        chk("midrst no push", 32'(a_empty), 1);
        chk("midrst stays idle", 32'(a_t_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
